// File: rtl/endian_swap_stage.sv
// Flow-controlled byte-order converter: one output register plus a skid register,
// swapping bytes (and keep bits) per beat at 16-bit, 32-bit or full-width granularity.
module endian_swap_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_W-1:0]   in_data_i,
  input  logic [DATA_W/8-1:0] in_keep_i,
  input  logic [1:0]          in_mode_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [DATA_W/8-1:0] out_keep_o,
  output logic [CNT_W-1:0]    beat_cnt_o
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {
    SWAP_NONE = 2'd0,
    SWAP_16   = 2'd1,
    SWAP_32   = 2'd2,
    SWAP_ALL  = 2'd3
  } swap_mode_e;

  swap_mode_e          mode;
  logic [DATA_W-1:0]   sw_data;
  logic [NB-1:0]       sw_keep;

  logic                main_valid;
  logic [DATA_W-1:0]   main_data;
  logic [NB-1:0]       main_keep;
  logic                skid_valid;
  logic [DATA_W-1:0]   skid_data;
  logic [NB-1:0]       skid_keep;
  logic [CNT_W-1:0]    beat_cnt;

  logic                accept;
  logic                drain;

  assign mode = swap_mode_e'(in_mode_i);

  always_comb begin
    sw_data = in_data_i;
    sw_keep = in_keep_i;
    case (mode)
      SWAP_16: begin
        for (int unsigned h = 0; h < NB / 2; h++) begin
          sw_data[16*h +: 8]   = in_data_i[16*h+8 +: 8];
          sw_data[16*h+8 +: 8] = in_data_i[16*h +: 8];
          sw_keep[2*h]         = in_keep_i[2*h+1];
          sw_keep[2*h+1]       = in_keep_i[2*h];
        end
      end
      SWAP_32: begin
        for (int unsigned w = 0; w < NB / 4; w++) begin
          for (int unsigned b = 0; b < 4; b++) begin
            sw_data[32*w+8*b +: 8] = in_data_i[32*w+8*(3-b) +: 8];
            sw_keep[4*w+b]         = in_keep_i[4*w+(3-b)];
          end
        end
      end
      SWAP_ALL: begin
        sw_data = {<<8{in_data_i}};
        sw_keep = {<<{in_keep_i}};
      end
      default: ;
    endcase
  end

  assign accept = in_valid_i && !skid_valid;
  assign drain  = main_valid && out_ready_i;

  // Skid only fills when main is held by a stalled consumer; ready is the
  // registered skid flag, so out_ready_i never reaches in_ready_o combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_keep  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      beat_cnt   <= '0;
    end else begin
      if (drain) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (skid_valid) begin
        if (drain) begin
          main_data  <= skid_data;
          main_keep  <= skid_keep;
          skid_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid || out_ready_i) begin
          main_data  <= sw_data;
          main_keep  <= sw_keep;
          main_valid <= 1'b1;
        end else begin
          skid_data  <= sw_data;
          skid_keep  <= sw_keep;
          skid_valid <= 1'b1;
        end
      end else if (drain) begin
        main_valid <= 1'b0;
      end
    end
  end

  assign in_ready_o  = !skid_valid;
  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign out_keep_o  = main_keep;
  assign beat_cnt_o  = beat_cnt;

endmodule

// File: tb/tb_endian_swap_stage.sv
// Bench for endian_swap_stage: a 32-bit instance (4-bit counter) and a 64-bit instance,
// checked against a byte-index reference model and a FIFO of outstanding beats.
module tb_endian_swap_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_id, a_od;
  logic [3:0]  a_ik, a_ok;
  logic [1:0]  a_im;
  logic [3:0]  a_cnt;

  logic        b_iv, b_ir, b_ov, b_or;
  logic [63:0] b_id, b_od;
  logic [7:0]  b_ik, b_ok;
  logic [1:0]  b_im;
  logic [15:0] b_cnt;

  int checks = 0;
  int failures = 0;
  int unsigned b_cnt_m = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
  } beat_t;

  endian_swap_stage #(.DATA_W(32), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id), .in_keep_i(a_ik), .in_mode_i(a_im),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .out_keep_o(a_ok),
    .beat_cnt_o(a_cnt)
  );

  endian_swap_stage #(.DATA_W(64), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id), .in_keep_i(b_ik), .in_mode_i(b_im),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .out_keep_o(b_ok),
    .beat_cnt_o(b_cnt)
  );

  function automatic int src_idx(input int j, input int n, input logic [1:0] m);
    case (m)
      2'd0:    return j;
      2'd1:    return j ^ 1;
      2'd2:    return j ^ 3;
      default: return n - 1 - j;
    endcase
  endfunction

  function automatic logic [63:0] ref_data(input logic [63:0] d, input int n, input logic [1:0] m);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[8*j +: 8] = d[8*src_idx(j, n, m) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] ref_keep(input logic [7:0] k, input int n, input logic [1:0] m);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j] = k[src_idx(j, n, m)];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_iv = 0; a_id = '0; a_ik = '0; a_im = '0; a_or = 1;
    b_iv = 0; b_id = '0; b_ik = '0; b_im = '0; b_or = 1;
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    next_cycle();
    @(negedge clk);
    checks++; if (a_ir !== 1'b1) begin failures++; $display("FAIL rst_a_ready got=%b exp=1", a_ir); end
    checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL rst_b_ready got=%b exp=1", b_ir); end
    next_cycle();
    reset = 0;
    b_cnt_m = 0;
    @(negedge clk);
    checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL rst_a_valid got=%b exp=0", a_ov); end
    checks++; if (a_od !== 32'h0 || a_ok !== 4'h0) begin failures++; $display("FAIL rst_a_data got=%h/%h exp=0/0", a_od, a_ok); end
    checks++; if (a_cnt !== 4'd0) begin failures++; $display("FAIL rst_a_cnt got=%0d exp=0", a_cnt); end
    checks++; if (b_ov !== 1'b0) begin failures++; $display("FAIL rst_b_valid got=%b exp=0", b_ov); end
    checks++; if (b_od !== 64'h0 || b_ok !== 8'h0) begin failures++; $display("FAIL rst_b_data got=%h/%h exp=0/0", b_od, b_ok); end
    checks++; if (b_cnt !== 16'd0) begin failures++; $display("FAIL rst_b_cnt got=%0d exp=0", b_cnt); end
    next_cycle();
  endtask

  task automatic test_modes32();
    logic [1:0]  tm[4];
    logic [3:0]  tk[4], tek[4];
    logic [31:0] te[4];
    int unsigned cnt_m;
    tm[0] = 2'd3; tk[0] = 4'b0001; te[0] = 32'h44332211; tek[0] = 4'b1000;
    tm[1] = 2'd1; tk[1] = 4'b0001; te[1] = 32'h22114433; tek[1] = 4'b0010;
    tm[2] = 2'd0; tk[2] = 4'b0110; te[2] = 32'h11223344; tek[2] = 4'b0110;
    tm[3] = 2'd2; tk[3] = 4'b0011; te[3] = 32'h44332211; tek[3] = 4'b1100;
    cnt_m = 0;
    for (int i = 0; i < 4; i++) begin
      a_iv = 1; a_id = 32'h11223344; a_ik = tk[i]; a_im = tm[i]; a_or = 1;
      @(negedge clk);
      checks++; if (a_ir !== 1'b1) begin failures++; $display("FAIL m32_ready[%0d] got=%b exp=1", i, a_ir); end
      next_cycle();
      a_iv = 0; a_id = $urandom; a_im = 2'($urandom);
      @(negedge clk);
      checks++;
      if (a_ov !== 1'b1 || a_od !== te[i] || a_ok !== tek[i]) begin
        failures++;
        $display("FAIL m32_out[%0d] got v=%b d=%h k=%b exp v=1 d=%h k=%b", i, a_ov, a_od, a_ok, te[i], tek[i]);
      end
      checks++; if (a_cnt !== 4'(cnt_m)) begin failures++; $display("FAIL m32_cnt_pre[%0d] got=%0d exp=%0d", i, a_cnt, cnt_m); end
      next_cycle();
      cnt_m++;
      @(negedge clk);
      checks++; if (a_cnt !== 4'(cnt_m) || a_ov !== 1'b0) begin failures++; $display("FAIL m32_cnt_post[%0d] got cnt=%0d v=%b exp cnt=%0d v=0", i, a_cnt, a_ov, cnt_m); end
      next_cycle();
    end
  endtask

  task automatic test_modes64();
    logic [1:0]  tm[4];
    logic [7:0]  tk[4], tek[4];
    logic [63:0] te[4];
    tm[0] = 2'd2; tk[0] = 8'hff;        te[0] = 64'h3322110077665544; tek[0] = 8'hff;
    tm[1] = 2'd3; tk[1] = 8'b00000011;  te[1] = 64'h7766554433221100; tek[1] = 8'b11000000;
    tm[2] = 2'd1; tk[2] = 8'b00000001;  te[2] = 64'h1100332255447766; tek[2] = 8'b00000010;
    tm[3] = 2'd0; tk[3] = 8'h00;        te[3] = 64'h0011223344556677; tek[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b_iv = 1; b_id = 64'h0011223344556677; b_ik = tk[i]; b_im = tm[i]; b_or = 0;
      next_cycle();
      b_iv = 0; b_im = 2'($urandom);
      @(negedge clk);
      checks++;
      if (b_ov !== 1'b1 || b_od !== te[i] || b_ok !== tek[i]) begin
        failures++;
        $display("FAIL m64_out[%0d] got v=%b d=%h k=%b exp v=1 d=%h k=%b", i, b_ov, b_od, b_ok, te[i], tek[i]);
      end
      b_or = 1;
      next_cycle();
      b_cnt_m++;
      @(negedge clk);
      checks++; if (b_cnt !== 16'(b_cnt_m) || b_ov !== 1'b0) begin failures++; $display("FAIL m64_cnt[%0d] got cnt=%0d v=%b exp cnt=%0d v=0", i, b_cnt, b_ov, b_cnt_m); end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] bd[3], ed[3];
    logic [7:0]  bk[3], ek[3];
    logic [1:0]  bm[3];
    for (int i = 0; i < 3; i++) begin
      bd[i] = {$urandom, $urandom}; bk[i] = 8'($urandom); bm[i] = 2'($urandom);
      ed[i] = ref_data(bd[i], 8, bm[i]); ek[i] = ref_keep(bk[i], 8, bm[i]);
    end
    b_or = 0;
    b_iv = 1; b_id = bd[0]; b_ik = bk[0]; b_im = bm[0];
    @(negedge clk);
    checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL bp_ready_a got=%b exp=1", b_ir); end
    next_cycle();
    b_id = bd[1]; b_ik = bk[1]; b_im = bm[1];
    @(negedge clk);
    checks++; if (b_ir !== 1'b1 || b_ov !== 1'b1 || b_od !== ed[0]) begin failures++; $display("FAIL bp_after_a got r=%b v=%b d=%h exp r=1 v=1 d=%h", b_ir, b_ov, b_od, ed[0]); end
    next_cycle();
    b_id = bd[2]; b_ik = bk[2]; b_im = bm[2];
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if (b_ir !== 1'b0 || b_ov !== 1'b1 || b_od !== ed[0] || b_ok !== ek[0]) begin
        failures++;
        $display("FAIL bp_stall[%0d] got r=%b v=%b d=%h k=%h exp r=0 v=1 d=%h k=%h", s, b_ir, b_ov, b_od, b_ok, ed[0], ek[0]);
      end
      next_cycle();
    end
    b_or = 1;
    @(negedge clk);
    checks++; if (b_od !== ed[0] || b_ir !== 1'b0) begin failures++; $display("FAIL bp_release got r=%b d=%h exp r=0 d=%h", b_ir, b_od, ed[0]); end
    next_cycle();
    b_cnt_m++;
    @(negedge clk);
    checks++; if (b_ov !== 1'b1 || b_od !== ed[1] || b_ok !== ek[1] || b_ir !== 1'b1) begin failures++; $display("FAIL bp_out_b got r=%b v=%b d=%h k=%h exp r=1 v=1 d=%h k=%h", b_ir, b_ov, b_od, b_ok, ed[1], ek[1]); end
    next_cycle();
    b_cnt_m++;
    b_iv = 0;
    @(negedge clk);
    checks++; if (b_ov !== 1'b1 || b_od !== ed[2] || b_ok !== ek[2]) begin failures++; $display("FAIL bp_out_c got v=%b d=%h k=%h exp v=1 d=%h k=%h", b_ov, b_od, b_ok, ed[2], ek[2]); end
    next_cycle();
    b_cnt_m++;
    @(negedge clk);
    checks++; if (b_ov !== 1'b0 || b_cnt !== 16'(b_cnt_m)) begin failures++; $display("FAIL bp_done got v=%b cnt=%0d exp v=0 cnt=%0d", b_ov, b_cnt, b_cnt_m); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [63:0] ed[100];
    logic [7:0]  ek[100];
    int errs;
    errs = 0;
    b_or = 1;
    for (int cyc = 0; cyc <= 100; cyc++) begin
      if (cyc < 100) begin
        b_iv = 1; b_id = {$urandom, $urandom}; b_ik = 8'($urandom); b_im = 2'($urandom);
        ed[cyc] = ref_data(b_id, 8, b_im); ek[cyc] = ref_keep(b_ik, 8, b_im);
      end else begin
        b_iv = 0;
      end
      @(negedge clk);
      if (cyc < 100) begin
        checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", cyc, b_ir); end
      end
      if (cyc >= 1) begin
        checks++;
        if (b_ov !== 1'b1 || b_od !== ed[cyc-1] || b_ok !== ek[cyc-1]) begin
          failures++;
          $display("FAIL b2b_out[%0d] got v=%b d=%h k=%h exp v=1 d=%h k=%h", cyc-1, b_ov, b_od, b_ok, ed[cyc-1], ek[cyc-1]);
        end
      end
      next_cycle();
    end
    b_cnt_m = (b_cnt_m + 100) % 65536;
    @(negedge clk);
    checks++; if (b_ov !== 1'b0 || b_cnt !== 16'(b_cnt_m)) begin failures++; $display("FAIL b2b_end got v=%b cnt=%0d exp v=0 cnt=%0d", b_ov, b_cnt, b_cnt_m); end
    next_cycle();
  endtask

  task automatic test_random_stall();
    beat_t q[$];
    beat_t nb;
    bit acc, ohs;
    q.delete();
    b_iv = 0;
    for (int cyc = 0; cyc < 304; cyc++) begin
      if (cyc >= 300) begin
        b_iv = 0; b_or = 1;
      end else begin
        if (!b_iv && ($urandom_range(9) < 7)) begin
          b_iv = 1; b_id = {$urandom, $urandom}; b_ik = 8'($urandom); b_im = 2'($urandom);
        end else if (!b_iv) begin
          b_im = 2'($urandom);
        end
        b_or = ($urandom_range(2) != 0);
      end
      @(negedge clk);
      checks++;
      if (b_ov !== (q.size() > 0) || b_ir !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rnd_flags[%0d] got v=%b r=%b exp v=%b r=%b", cyc, b_ov, b_ir, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        checks++;
        if (b_od !== q[0].d || b_ok !== q[0].k) begin
          failures++;
          $display("FAIL rnd_out[%0d] got d=%h k=%h exp d=%h k=%h", cyc, b_od, b_ok, q[0].d, q[0].k);
        end
      end
      checks++; if (b_cnt !== 16'(b_cnt_m)) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", cyc, b_cnt, b_cnt_m); end
      acc = b_iv && b_ir;
      ohs = b_ov && b_or;
      if (ohs && q.size() > 0) begin
        void'(q.pop_front());
        b_cnt_m = (b_cnt_m + 1) % 65536;
      end
      if (acc) begin
        nb.d = ref_data(b_id, 8, b_im);
        nb.k = ref_keep(b_ik, 8, b_im);
        q.push_back(nb);
      end
      next_cycle();
      if (acc) b_iv = 0;
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] dd, ed;
    b_or = 0;
    for (int i = 0; i < 2; i++) begin
      b_iv = 1; b_id = {$urandom, $urandom}; b_ik = 8'hff; b_im = 2'($urandom);
      next_cycle();
    end
    b_iv = 0;
    @(negedge clk);
    checks++; if (b_ir !== 1'b0 || b_ov !== 1'b1) begin failures++; $display("FAIL rmid_full got r=%b v=%b exp r=0 v=1", b_ir, b_ov); end
    reset = 1;
    next_cycle();
    reset = 0;
    b_cnt_m = 0;
    dd = {$urandom, $urandom};
    ed = ref_data(dd, 8, 2'd3);
    b_iv = 1; b_id = dd; b_ik = 8'h0f; b_im = 2'd3;
    @(negedge clk);
    checks++;
    if (b_ov !== 1'b0 || b_cnt !== 16'd0 || b_ir !== 1'b1) begin
      failures++;
      $display("FAIL rmid_reset got v=%b cnt=%0d r=%b exp v=0 cnt=0 r=1", b_ov, b_cnt, b_ir);
    end
    next_cycle();
    b_iv = 0;
    @(negedge clk);
    checks++; if (b_ov !== 1'b1 || b_od !== ed || b_ok !== 8'hf0) begin failures++; $display("FAIL rmid_first got v=%b d=%h k=%h exp v=1 d=%h k=f0", b_ov, b_od, b_ok, ed); end
    b_or = 1;
    next_cycle();
    b_cnt_m = 1;
    @(negedge clk);
    checks++; if (b_ov !== 1'b0 || b_cnt !== 16'(b_cnt_m)) begin failures++; $display("FAIL rmid_drain got v=%b cnt=%0d exp v=0 cnt=1", b_ov, b_cnt); end
    next_cycle();
  endtask

  task automatic test_counter_wrap();
    logic [31:0] ed[17];
    a_or = 1;
    for (int cyc = 0; cyc <= 18; cyc++) begin
      if (cyc < 17) begin
        a_iv = 1; a_id = $urandom; a_ik = 4'($urandom); a_im = 2'($urandom);
        ed[cyc] = 32'(ref_data({32'h0, a_id}, 4, a_im));
      end else begin
        a_iv = 0;
      end
      @(negedge clk);
      if (cyc >= 1) begin
        checks++;
        if (a_cnt !== 4'((cyc - 1) % 16)) begin
          failures++;
          $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", cyc, a_cnt, (cyc - 1) % 16);
        end
      end
      if (cyc >= 1 && cyc <= 17) begin
        checks++; if (a_ov !== 1'b1 || a_od !== ed[cyc-1]) begin failures++; $display("FAIL wrap_out[%0d] got v=%b d=%h exp v=1 d=%h", cyc-1, a_ov, a_od, ed[cyc-1]); end
      end
      next_cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_modes32();
    test_modes64();
    test_backpressure();
    test_back_to_back();
    test_random_stall();
    test_reset_midflight();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/endian_swap_stage.md
# endian_swap_stage

Parametrised, flow-controlled byte-order converter for the datapath. Each accepted beat is byte-swapped at a runtime-selectable granularity: pass-through, 16-bit, 32-bit, or full-width. Byte enables are swapped identically to the data. The block is a one-stage pipeline with a two-entry skid buffer, so it drops between any valid/ready producer and consumer without breaking timing. It carries a wrapping beat counter for debug.

## Interface
- DATA_W, 64, data width in bits; must be a multiple of 32 and ≥ 32
- CNT_W, 16, width of the beat counter
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- in_valid_i  input  1  input beat valid
- in_ready_o  output  1  block can accept a beat
- in_data_i  input  DATA_W  input data; byte k = bits [8k+7:8k]
- in_keep_i  input  DATA_W/8  byte enables; bit k qualifies byte k
- in_mode_i  input  2  swap mode, sampled with the beat: 0 none, 1 swap within 16-bit, 2 swap within 32-bit, 3 full reverse
- out_valid_o  output  1  output beat valid
- out_ready_i  input  1  downstream accepts
- out_data_o  output  DATA_W  converted data
- out_keep_o  output  DATA_W/8  converted byte enables
- beat_cnt_o  output  CNT_W  number of beats delivered on the output, wrapping

## Operation
- Byte mapping for output byte j, with N = DATA_W/8:
  - mode 0: source byte j.
  - mode 1: source byte j XOR 1.
  - mode 2: source byte j XOR 3.
  - mode 3: source byte N-1-j.
- The keep bits use the same mapping as the data.
- Mode is captured per beat at acceptance. Changing in_mode_i never alters beats already held.
- An input handshake occurs when in_valid_i && in_ready_o. An output handshake occurs when out_valid_o && out_ready_i.
- Storage is a main output register (drives out_*) plus one skid register. Both hold post-swap values.
- in_ready_o = !skid_valid. It is driven straight from the register with no combinational path from out_ready_i.
- Accept, main register empty or draining this cycle: the beat goes into the main register.
- Accept, main register full and stalled: the beat goes into the skid register, and in_ready_o drops the next cycle.
- Output handshake with the skid register full: skid moves into main, and the skid register empties.
- Output handshake with an input accepted in the same cycle and skid empty: the new beat replaces main. out_valid_o stays 1 (full throughput, one beat per cycle).
- Outputs are stable while out_valid_o && !out_ready_i. Data and keep must not change.
- No bubbles: sustained valid plus ready on both sides gives one beat per cycle indefinitely.
- beat_cnt_o increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- No beat is ever dropped or duplicated.
- in_keep_i = 0 is a legal beat and is passed through.

## Timing
- Latency: a beat accepted in cycle t appears on out_*_o in cycle t+1 when the output path is free.
- Reset values, all synchronous:
  - out_valid_o = 0
  - skid_valid = 0, so in_ready_o = 1 during and after reset
  - out_data_o = 0
  - out_keep_o = 0
  - beat_cnt_o = 0
- Reset mid-transfer discards both held beats. The first beat accepted after reset deasserts appears at t+1.
- Both registers full, output stalled: in_ready_o = 0. The input side must hold its beat, per standard valid/ready rules.
- Skid full, out_ready_i rises in cycle t: the main beat leaves at t. The skid beat appears at t+1, and in_ready_o = 1 at t+1.

## Test plan
- DATA_W=32, mode 3, in_data 0x11223344, keep 4'b0001 -> out_data 0x44332211, keep 4'b1000 one cycle later; beat_cnt_o 0→1 on handshake.
- DATA_W=32, mode 1, in_data 0x11223344 -> 0x22114433. Mode 0 -> 0x11223344 unchanged.
- DATA_W=64, modes 2 and 3, in_data 0x0011223344556677:
  - mode 2 -> 0x3322110077665544
  - mode 3 -> 0x7766554433221100, with keep 8'b00000011 -> 8'b11000000
- Backpressure:
  - Hold out_ready_i=0 and send 3 beats: A, B accepted; in_ready_o=0 after B; C held.
  - Release ready: A, B, C delivered in order with no loss or duplication.
  - Outputs stay stable while stalled.
- Throughput: 100 back-to-back beats with random mode per beat, ready always 1 -> 100 outputs on consecutive cycles, each matching the mode it was accepted with. Then assert reset with 2 beats held -> out_valid_o=0, beat_cnt_o=0 the next cycle.
- Counter wrap: CNT_W=4, deliver 17 beats -> beat_cnt_o reads 15 after beat 15, 0 after beat 16, and 1 after beat 17.
